ultrasonic_ranging_ctrl: RTL and testbench
==========================================

ULTRASONIC_RANGING_CTRL -- requirements
Module: ultrasonic_ranging_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  TX_CYCLES  40  transmit burst length, cycles
  BLANK_CYCLES  200  post-burst ringdown blanking, cycles
  WINDOW_CYCLES  5000  echo listen window, cycles
  GAP_CYCLES  1000  inter-measurement gap, cycles
  CNT_W  16  time-of-flight counter width
REQ-002 Ports SHALL be (name, direction, width, meaning):
  gclk  in  1  single clock, rising edge
  rst  in  1  asynchronous active-high reset
  start  in  1  request one measurement, level-sampled
  continuous  in  1  auto-repeat measurements while high
  abort  in  1  cancel measurement in progress
  detected  in  1  one-cycle echo pulse from detection block
  tx_en  out  1  transmitter burst enable
  detect_en  out  1  detection block enable
  busy  out  1  measurement cycle in progress
  tof  out  CNT_W  captured time of flight, cycles since burst start
  tof_valid  out  1  one-cycle pulse, new tof
  timeout  out  1  one-cycle pulse, window expired without echo
REQ-003 The clock SHALL be gclk only; reset SHALL be rst, asynchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, TX, BLANK, LISTEN, GAP; every output SHALL be registered.
REQ-005 IDLE: start=1 or continuous=1 sampled at an edge -> TX from the next cycle.
REQ-006 TX: tx_en=1 for exactly TX_CYCLES cycles, then BLANK.
REQ-007 BLANK: tx_en=0, detect_en=0 for exactly BLANK_CYCLES cycles; detected SHALL be ignored; then LISTEN.
REQ-008 LISTEN: detect_en=1 for at most WINDOW_CYCLES cycles.
REQ-009 Flight counter SHALL read 0 in the first TX cycle, increment by 1 every cycle through TX, BLANK and LISTEN, and saturate at 2^CNT_W-1 (no wrap).
REQ-010 detected=1 in a LISTEN cycle -> tof := counter value of that cycle; tof_valid=1 for the next cycle only; state -> GAP.
REQ-011 Window expiry without detected -> timeout=1 for the next cycle only; tof unchanged; state -> GAP.
REQ-012 detected on the final LISTEN cycle SHALL count as an echo (tof_valid, no timeout).
REQ-013 tof_valid and timeout SHALL never be asserted in the same cycle.
REQ-014 GAP: all enables 0 for exactly GAP_CYCLES cycles; then TX if continuous=1, else IDLE.
REQ-015 busy=1 in every state except IDLE; start SHALL be ignored while busy.
REQ-016 abort=1 in any non-IDLE state -> IDLE next cycle; tx_en, detect_en 0 from that cycle; no tof_valid or timeout generated; tof unchanged.
REQ-017 abort has priority over detected and window expiry in the same cycle; abort in IDLE has no effect and overrides start.
REQ-018 Parameters with zero value are illegal; BLANK_CYCLES=1 and WINDOW_CYCLES=1 SHALL work.

Reset
REQ-019 rst=1 SHALL immediately force state IDLE, counter 0, tof 0, tx_en, detect_en, busy, tof_valid, timeout all 0, regardless of state.
REQ-020 After rst deasserts, a measurement SHALL start only on a subsequent start or continuous sample.

Verification (TX=4, BLANK=3, WINDOW=10, GAP=2, CNT_W=8; cycle 0 = first TX cycle)
REQ-021 start pulse; detected at cycle 12 -> tx_en cycles 0-3, detect_en cycles 7-12, tof=12 with tof_valid at cycle 13, busy low at cycle 16.
REQ-022 start; no detected -> detect_en cycles 7-16, timeout at cycle 17 only, tof keeps prior value, no tof_valid.
REQ-023 detected at cycle 5 (BLANK) then none -> ignored, timeout at cycle 17; detected at cycle 16 instead -> tof=16, tof_valid, no timeout.
REQ-024 abort at cycle 9 simultaneous with detected -> IDLE at cycle 10, busy=0, detect_en=0, no tof_valid/timeout.
REQ-025 continuous held high, echo at cycle 12 -> GAP cycles 13-14, next tx_en at cycle 15 with counter 0; start pulses while busy cause no extra burst.
REQ-026 rst asserted mid-TX (cycle 2) -> tx_en, busy, tof, pulses 0 without waiting for gclk; idle until next start.

Source files
------------

// File: rtl/ultrasonic_ranging_ctrl.sv
// Ultrasonic ranging sequencer: transmit burst, ringdown blanking, echo listen
// window and inter-measurement gap, with a saturating time-of-flight counter.
module ultrasonic_ranging_ctrl #(
    parameter int TX_CYCLES     = 40,
    parameter int BLANK_CYCLES  = 200,
    parameter int WINDOW_CYCLES = 5000,
    parameter int GAP_CYCLES    = 1000,
    parameter int CNT_W         = 16
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic             detected,
    output logic             tx_en,
    output logic             detect_en,
    output logic             busy,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic             timeout
);

    localparam int MAX_AB = (TX_CYCLES > BLANK_CYCLES) ? TX_CYCLES : BLANK_CYCLES;
    localparam int MAX_CD = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
    localparam int MAX_PH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int PH_W   = $clog2(MAX_PH) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PH_W-1:0]   ph_r;
    logic              ph_last_s;
    logic [CNT_W-1:0]  cnt_r;

    logic              tx_en_s;
    logic              detect_en_s;
    logic              busy_s;
    logic              tof_valid_s;
    logic              timeout_s;
    logic [CNT_W-1:0]  tof_s;

    // State register
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort outranks echo and window expiry
    always_comb begin
        state_s   = state_r;
        ph_last_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!abort && (start || continuous)) begin
                    state_s = S_TX;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TX: begin
                ph_last_s = (ph_r == PH_W'(TX_CYCLES - 1));
                if (abort) begin
                    state_s = S_IDLE;
                end else if (ph_last_s) begin
                    state_s = S_BLANK;
                end else begin
                    state_s = S_TX;
                end
            end
            S_BLANK: begin
                ph_last_s = (ph_r == PH_W'(BLANK_CYCLES - 1));
                if (abort) begin
                    state_s = S_IDLE;
                end else if (ph_last_s) begin
                    state_s = S_LISTEN;
                end else begin
                    state_s = S_BLANK;
                end
            end
            S_LISTEN: begin
                ph_last_s = (ph_r == PH_W'(WINDOW_CYCLES - 1));
                if (abort) begin
                    state_s = S_IDLE;
                end else if (detected || ph_last_s) begin
                    state_s = S_GAP;
                end else begin
                    state_s = S_LISTEN;
                end
            end
            S_GAP: begin
                ph_last_s = (ph_r == PH_W'(GAP_CYCLES - 1));
                if (abort) begin
                    state_s = S_IDLE;
                end else if (ph_last_s) begin
                    state_s = continuous ? S_TX : S_IDLE;
                end else begin
                    state_s = S_GAP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered enables align with it
    always_comb begin
        tx_en_s     = (state_s == S_TX);
        detect_en_s = (state_s == S_LISTEN);
        busy_s      = (state_s != S_IDLE);
        tof_valid_s = (state_r == S_LISTEN) && !abort && detected;
        timeout_s   = (state_r == S_LISTEN) && !abort && !detected && ph_last_s;
        if (tof_valid_s) begin
            tof_s = cnt_r;
        end else begin
            tof_s = tof;
        end
    end

    // Per-state cycle counter, restarted on every state change
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            ph_r <= '0;
        end else if (state_s != state_r) begin
            ph_r <= '0;
        end else begin
            ph_r <= ph_r + PH_W'(1);
        end
    end

    // Flight counter: zero in the first TX cycle, saturating through TX/BLANK/LISTEN
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if ((state_s == S_TX) && (state_r != S_TX)) begin
            cnt_r <= '0;
        end else if (((state_r == S_TX) || (state_r == S_BLANK) || (state_r == S_LISTEN))
                     && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered outputs
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            tx_en     <= 1'b0;
            detect_en <= 1'b0;
            busy      <= 1'b0;
            tof       <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tx_en     <= tx_en_s;
            detect_en <= detect_en_s;
            busy      <= busy_s;
            tof       <= tof_s;
            tof_valid <= tof_valid_s;
            timeout   <= timeout_s;
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranging_ctrl.sv
// Scoreboard bench for ultrasonic_ranging_ctrl with a small parameter set
// (TX=4, BLANK=3, WINDOW=10, GAP=2, CNT_W=8); cycle 0 is the first TX cycle.
module tb_ultrasonic_ranging_ctrl;

    localparam int NMAX = 64;

    logic       gclk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       abort = 1'b0;
    logic       detected = 1'b0;
    logic       tx_en;
    logic       detect_en;
    logic       busy;
    logic [7:0] tof;
    logic       tof_valid;
    logic       timeout;

    ultrasonic_ranging_ctrl #(
        .TX_CYCLES(4), .BLANK_CYCLES(3), .WINDOW_CYCLES(10), .GAP_CYCLES(2), .CNT_W(8)
    ) dut (
        .gclk(gclk), .rst(rst), .start(start), .continuous(continuous),
        .abort(abort), .detected(detected), .tx_en(tx_en), .detect_en(detect_en),
        .busy(busy), .tof(tof), .tof_valid(tof_valid), .timeout(timeout)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        int         cyc;
        bit         is_to;
        logic [7:0] tof;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic det_m [0:NMAX-1];
    logic ab_m  [0:NMAX-1];
    logic st_m  [0:NMAX-1];
    logic ct_m  [0:NMAX-1];

    logic       obs_tx  [0:NMAX-1];
    logic       obs_de  [0:NMAX-1];
    logic       obs_bsy [0:NMAX-1];
    logic       obs_tv  [0:NMAX-1];
    logic       obs_to  [0:NMAX-1];
    logic [7:0] obs_tof [0:NMAX-1];

    task automatic clear_masks();
        for (int i = 0; i < NMAX; i++) begin
            det_m[i] = 1'b0; ab_m[i] = 1'b0; st_m[i] = 1'b0; ct_m[i] = 1'b0;
        end
    endtask

    // Issue a start at the next edge; returns #1 into cycle 0
    task automatic begin_meas();
        continuous = ct_m[0];
        start = 1'b1;
        @(posedge gclk);
        #1;
        start = 1'b0;
    endtask

    // Drive per-cycle masks and record outputs mid-cycle (stimulus only)
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            detected = det_m[c]; abort = ab_m[c]; start = st_m[c]; continuous = ct_m[c];
            @(negedge gclk);
            obs_tx[c] = tx_en; obs_de[c] = detect_en; obs_bsy[c] = busy;
            obs_tv[c] = tof_valid; obs_to[c] = timeout; obs_tof[c] = tof;
            @(posedge gclk);
            #1;
        end
        detected = 1'b0; abort = 1'b0; start = 1'b0; continuous = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge gclk);
        n_cmp++; if ({tx_en, detect_en, busy, tof_valid, timeout} !== 5'b0) begin
            n_bad++; $display("FAIL reset_outs got=%b want=00000", {tx_en, detect_en, busy, tof_valid, timeout});
        end
        n_cmp++; if (tof !== 8'd0) begin
            n_bad++; $display("FAIL reset_tof got=%0d want=0", tof);
        end
        rst = 1'b0;
        @(posedge gclk); #1;
        clear_masks();
        run_cycles(5);
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (obs_bsy[c] !== 1'b0 || obs_tx[c] !== 1'b0) begin
                n_bad++; $display("FAIL post_reset_idle c=%0d busy=%b tx=%b want 0 0", c, obs_bsy[c], obs_tx[c]);
            end
        end
    endtask

    task automatic test_echo();
        clear_masks();
        det_m[12] = 1'b1;
        sb.push_back('{cyc: 13, is_to: 1'b0, tof: 8'd12});
        begin_meas();
        run_cycles(20);
        for (int c = 0; c < 16; c++) begin
            n_cmp++; if (obs_tx[c] !== (c <= 3)) begin
                n_bad++; $display("FAIL echo_tx_en c=%0d got=%b want=%b", c, obs_tx[c], (c <= 3));
            end
            n_cmp++; if (obs_de[c] !== (c >= 7 && c <= 12)) begin
                n_bad++; $display("FAIL echo_detect_en c=%0d got=%b want=%b", c, obs_de[c], (c >= 7 && c <= 12));
            end
        end
        n_cmp++; if (obs_bsy[14] !== 1'b1 || obs_bsy[16] !== 1'b0) begin
            n_bad++; $display("FAIL echo_busy c14=%b c16=%b want 1 0", obs_bsy[14], obs_bsy[16]);
        end
        for (int c = 0; c < 20; c++) if (obs_tv[c] || obs_to[c]) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL echo_pulse extra c=%0d tv=%b to=%b want none", c, obs_tv[c], obs_to[c]);
            end else begin
                e = sb.pop_front();
                if (c != e.cyc || obs_to[c] !== e.is_to || obs_tv[c] !== !e.is_to || obs_tof[c] !== e.tof) begin
                    n_bad++; $display("FAIL echo_pulse c=%0d to=%b tof=%0d want c=%0d to=%b tof=%0d", c, obs_to[c], obs_tof[c], e.cyc, e.is_to, e.tof);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin
            n_bad++; $display("FAIL echo_missing got=%0d pending want=0", sb.size());
        end
        sb.delete();
    endtask

    // det_cyc < 0 means no echo at all
    task automatic test_window(input int det_cyc, input logic [7:0] prior_tof, input bit expect_to, input logic [7:0] want_tof);
        clear_masks();
        if (det_cyc >= 0) det_m[det_cyc] = 1'b1;
        sb.push_back('{cyc: 17, is_to: expect_to, tof: want_tof});
        begin_meas();
        run_cycles(22);
        for (int c = 0; c < 18; c++) begin
            n_cmp++; if (obs_de[c] !== (c >= 7 && c <= 16)) begin
                n_bad++; $display("FAIL window_detect_en det=%0d c=%0d got=%b want=%b", det_cyc, c, obs_de[c], (c >= 7 && c <= 16));
            end
        end
        n_cmp++; if (obs_tof[16] !== prior_tof) begin
            n_bad++; $display("FAIL window_prior_tof det=%0d got=%0d want=%0d", det_cyc, obs_tof[16], prior_tof);
        end
        for (int c = 0; c < 22; c++) if (obs_tv[c] || obs_to[c]) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL window_pulse extra det=%0d c=%0d tv=%b to=%b", det_cyc, c, obs_tv[c], obs_to[c]);
            end else begin
                e = sb.pop_front();
                if (c != e.cyc || obs_to[c] !== e.is_to || obs_tv[c] !== !e.is_to || obs_tof[c] !== e.tof) begin
                    n_bad++; $display("FAIL window_pulse det=%0d c=%0d tv=%b to=%b tof=%0d want c=%0d to=%b tof=%0d", det_cyc, c, obs_tv[c], obs_to[c], obs_tof[c], e.cyc, e.is_to, e.tof);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin
            n_bad++; $display("FAIL window_missing det=%0d got=%0d pending want=0", det_cyc, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_abort(input logic [7:0] prior_tof);
        clear_masks();
        det_m[9] = 1'b1;
        ab_m[9]  = 1'b1;
        begin_meas();
        run_cycles(16);
        n_cmp++; if (obs_bsy[9] !== 1'b1 || obs_de[9] !== 1'b1) begin
            n_bad++; $display("FAIL abort_pre c9 busy=%b de=%b want 1 1", obs_bsy[9], obs_de[9]);
        end
        n_cmp++; if (obs_bsy[10] !== 1'b0 || obs_de[10] !== 1'b0 || obs_tx[10] !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle c10 busy=%b de=%b tx=%b want 0 0 0", obs_bsy[10], obs_de[10], obs_tx[10]);
        end
        n_cmp++; if (obs_tof[12] !== prior_tof) begin
            n_bad++; $display("FAIL abort_tof got=%0d want=%0d", obs_tof[12], prior_tof);
        end
        for (int c = 0; c < 16; c++) if (obs_tv[c] || obs_to[c]) begin
            n_cmp++; n_bad++;
            $display("FAIL abort_pulse c=%0d tv=%b to=%b want none", c, obs_tv[c], obs_to[c]);
        end
        n_cmp++; if (obs_bsy[15] !== 1'b0) begin
            n_bad++; $display("FAIL abort_stays_idle busy=%b want 0", obs_bsy[15]);
        end
    endtask

    task automatic test_abort_idle();
        clear_masks();
        st_m[0] = 1'b1;
        ab_m[0] = 1'b1;
        run_cycles(4);
        for (int c = 1; c < 4; c++) begin
            n_cmp++; if (obs_bsy[c] !== 1'b0 || obs_tx[c] !== 1'b0) begin
                n_bad++; $display("FAIL abort_idle_start c=%0d busy=%b tx=%b want 0 0", c, obs_bsy[c], obs_tx[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_masks();
        for (int c = 0; c < 28; c++) ct_m[c] = 1'b1;
        det_m[12] = 1'b1;
        det_m[27] = 1'b1;
        st_m[5]   = 1'b1;
        st_m[20]  = 1'b1;
        sb.push_back('{cyc: 13, is_to: 1'b0, tof: 8'd12});
        sb.push_back('{cyc: 28, is_to: 1'b0, tof: 8'd12});
        begin_meas();
        run_cycles(34);
        for (int c = 0; c < 34; c++) begin
            n_cmp++; if (obs_tx[c] !== ((c <= 3) || (c >= 15 && c <= 18))) begin
                n_bad++; $display("FAIL b2b_tx_en c=%0d got=%b want=%b", c, obs_tx[c], ((c <= 3) || (c >= 15 && c <= 18)));
            end
        end
        n_cmp++; if (obs_bsy[13] !== 1'b1 || obs_bsy[14] !== 1'b1 || obs_de[13] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_gap busy13=%b busy14=%b de13=%b want 1 1 0", obs_bsy[13], obs_bsy[14], obs_de[13]);
        end
        n_cmp++; if (obs_bsy[31] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end busy=%b want 0", obs_bsy[31]);
        end
        for (int c = 0; c < 34; c++) if (obs_tv[c] || obs_to[c]) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL b2b_pulse extra c=%0d tv=%b to=%b", c, obs_tv[c], obs_to[c]);
            end else begin
                e = sb.pop_front();
                if (c != e.cyc || obs_to[c] !== e.is_to || obs_tv[c] !== !e.is_to || obs_tof[c] !== e.tof) begin
                    n_bad++; $display("FAIL b2b_pulse c=%0d to=%b tof=%0d want c=%0d to=%b tof=%0d", c, obs_to[c], obs_tof[c], e.cyc, e.is_to, e.tof);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin
            n_bad++; $display("FAIL b2b_missing got=%0d pending want=0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_tx();
        clear_masks();
        begin_meas();
        repeat (2) begin
            @(posedge gclk); #1;
        end
        rst = 1'b1;
        #2;
        n_cmp++; if ({tx_en, detect_en, busy, tof_valid, timeout} !== 5'b0) begin
            n_bad++; $display("FAIL async_reset_outs got=%b want=00000", {tx_en, detect_en, busy, tof_valid, timeout});
        end
        n_cmp++; if (tof !== 8'd0) begin
            n_bad++; $display("FAIL async_reset_tof got=%0d want=0", tof);
        end
        @(negedge gclk);
        rst = 1'b0;
        @(posedge gclk); #1;
        run_cycles(10);
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (obs_bsy[c] !== 1'b0 || obs_tx[c] !== 1'b0) begin
                n_bad++; $display("FAIL reset_then_idle c=%0d busy=%b tx=%b want 0 0", c, obs_bsy[c], obs_tx[c]);
            end
        end
    endtask

    // Simultaneous pulses are never allowed
    always @(negedge gclk) begin
        if (!rst && tof_valid === 1'b1 && timeout === 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL pulse_exclusive tv=%b to=%b want not both", tof_valid, timeout);
        end
    end

    initial begin
        clear_masks();
        test_reset();
        test_echo();
        test_window(-1, 8'd12, 1'b1, 8'd12);
        test_window(5, 8'd12, 1'b1, 8'd12);
        test_window(16, 8'd12, 1'b0, 8'd16);
        test_abort(8'd16);
        test_abort_idle();
        test_back_to_back();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
